// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial unsigned subtractor. An accepted start loads both operands.
//   One bit pair is then processed per clock, LSB first, for WIDTH cycles.
//   The result and the final borrow are published together with a single-cycle
//   done pulse.
//
// Ports
//   clk    in   clock; all state updates on the rising edge
//   rst_n  in   asynchronous, active-low reset
//   start  in   request a subtraction; accepted only while idle
//   a      in   minuend (unsigned), sampled on the accepting edge
//   b      in   subtrahend (unsigned), sampled on the accepting edge
//   diff   out  registered a-b modulo 2^WIDTH
//   bout   out  registered final borrow (a < b)
//   busy   out  high while bits are being shifted
//   done   out  single-cycle pulse in the cycle diff/bout are new
//
// States
//   state  | meaning
//   IDLE   | waiting for start; diff/bout hold the last result
//   SHIFT  | one bit pair consumed per cycle, WIDTH cycles in total
//   FINISH | result just published; done asserted for this one cycle

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  logic             a0, b0;
  logic             d_bit;
  logic             br_next;
  logic [WIDTH-1:0] res_next;
  logic             accept;
  logic             last_bit;

  // ---------------------------------------------------------------------------
  // Full-subtractor cell on the current LSBs
  // ---------------------------------------------------------------------------
  always_comb begin
    a0       = a_sh_q[0];
    b0       = b_sh_q[0];
    d_bit    = a0 ^ b0 ^ br_q;
    br_next  = (~a0 & b0) | (~(a0 ^ b0) & br_q);
    res_next = {d_bit, res_q[WIDTH-1:1]};
    accept   = (state_q == IDLE) && start;
    last_bit = (state_q == SHIFT) && (cnt_q == LAST_BIT);
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cnt_q == LAST_BIT) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      SHIFT:   busy = 1'b1;
      FINISH:  done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  assign diff = diff_q;
  assign bout = bout_q;

  // ---------------------------------------------------------------------------
  // Datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    a_sh_d = a_sh_q;
    b_sh_d = b_sh_q;
    res_d  = res_q;
    br_d   = br_q;
    cnt_d  = cnt_q;
    diff_d = diff_q;
    bout_d = bout_q;

    if (accept) begin
      a_sh_d = a;
      b_sh_d = b;
      res_d  = '0;
      br_d   = 1'b0;
      cnt_d  = '0;
    end else if (state_q == SHIFT) begin
      a_sh_d = a_sh_q >> 1;
      b_sh_d = b_sh_q >> 1;
      res_d  = res_next;
      br_d   = br_next;
      cnt_d  = cnt_q + CNT_ONE;
    end

    // The final bit lands in the result register on the same edge that
    // publishes it, so publish the freshly shifted value, not res_q.
    if (last_bit) begin
      diff_d = res_next;
      bout_d = br_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q <= '0;
      b_sh_q <= '0;
      res_q  <= '0;
      br_q   <= 1'b0;
      cnt_q  <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else begin
      a_sh_q <= a_sh_d;
      b_sh_q <= b_sh_d;
      res_q  <= res_d;
      br_q   <= br_d;
      cnt_q  <= cnt_d;
      diff_q <= diff_d;
      bout_q <= bout_d;
    end
  end

endmodule
